// File: rtl/byte_port_arbiter_pkg.sv
// Shared types and constants for the two-port byte arbiter.
package byte_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  // Identifies which requester a memory read belongs to.
  typedef logic owner_t;

  typedef enum logic {
    ISSUE = 1'b0,
    GAP   = 1'b1
  } state_t;

endpackage

// File: rtl/byte_port_arbiter_owner_fifo.sv
// Read-owner FIFO: records which requester issued each outstanding
// memory read so returning data can be steered back in issue order.
module owner_fifo
  import byte_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  owner_t din,
  output owner_t dout,
  output logic   full,
  output logic   empty
);

  localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] DEPTH = (PW + 1)'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] mem_q, mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW:0]                count_q, count_d;
  logic                       push_ok, pop_ok;

  assign full  = (count_q == DEPTH);
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap
  // naturally because the depth is a power of two.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/byte_port_arbiter.sv
// Two-requester byte memory port arbiter with command spacing and
// in-order read-data steering.
// Build option: define BYTE_ARB_FIXED_PRIORITY_EN to make requester 0
// win every contention (no round-robin history kept).
module byte_port_arbiter
  import byte_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 24,
  parameter int unsigned CYCLES          = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rq0_rd,
  input  logic                  rq0_wr,
  input  logic [ADDR_WIDTH-1:0] rq0_addr,
  input  logic [7:0]            rq0_wr_data,
  output logic                  rq0_ready,
  output logic [7:0]            rq0_rd_data,
  output logic                  rq0_rd_data_valid,
  input  logic                  rq1_rd,
  input  logic                  rq1_wr,
  input  logic [ADDR_WIDTH-1:0] rq1_addr,
  input  logic [7:0]            rq1_wr_data,
  output logic                  rq1_ready,
  output logic [7:0]            rq1_rd_data,
  output logic                  rq1_rd_data_valid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wr_data,
  input  logic [7:0]            mem_rd_data,
  input  logic                  mem_rd_data_valid,
  output logic                  err_orphan
);

  localparam logic [3:0] GAP_LOAD = 4'(CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] gap_q, gap_d;
  logic       err_orphan_q, err_orphan_d;
  logic [7:0] rd_data0_q, rd_data0_d;
  logic [7:0] rd_data1_q, rd_data1_d;
`ifndef BYTE_ARB_FIXED_PRIORITY_EN
  owner_t     last_grant_q, last_grant_d;
`endif

  logic   elig0, elig1, grant;
  owner_t sel;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  owner_t fifo_dout;

  owner_fifo #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (fifo_push),
    .pop    (fifo_pop),
    .din    (sel),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Grant selection and combinational drive of the memory command.
  always_comb begin
    elig0 = rq0_wr | (rq0_rd & ~fifo_full);
    elig1 = rq1_wr | (rq1_rd & ~fifo_full);
    sel   = 1'b0;
    if (elig0 && elig1) begin
`ifdef BYTE_ARB_FIXED_PRIORITY_EN
      sel = 1'b0;
`else
      sel = ~last_grant_q;
`endif
    end else if (elig1) begin
      sel = 1'b1;
    end
    grant       = reset_n & (state_q == ISSUE) & (elig0 | elig1);
    rq0_ready   = grant & ~sel;
    rq1_ready   = grant & sel;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (rq0_ready) begin
      mem_rd      = rq0_rd;
      mem_wr      = rq0_wr;
      mem_addr    = rq0_addr;
      mem_wr_data = rq0_wr_data;
    end else if (rq1_ready) begin
      mem_rd      = rq1_rd;
      mem_wr      = rq1_wr;
      mem_addr    = rq1_addr;
      mem_wr_data = rq1_wr_data;
    end
    fifo_push = mem_rd;
  end

  // Read-return steering: the FIFO head names the owner of each byte;
  // outputs pass the byte through in the return cycle and then hold it.
  always_comb begin
    fifo_pop          = mem_rd_data_valid;
    rq0_rd_data_valid = reset_n & mem_rd_data_valid & ~fifo_empty & (fifo_dout == 1'b0);
    rq1_rd_data_valid = reset_n & mem_rd_data_valid & ~fifo_empty & (fifo_dout == 1'b1);
    rd_data0_d        = rq0_rd_data_valid ? mem_rd_data : rd_data0_q;
    rd_data1_d        = rq1_rd_data_valid ? mem_rd_data : rd_data1_q;
    rq0_rd_data       = rd_data0_d;
    rq1_rd_data       = rd_data1_d;
    err_orphan_d      = err_orphan_q | (mem_rd_data_valid & fifo_empty);
    err_orphan        = err_orphan_q;
  end

  // Issue/gap sequencing and round-robin history.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
`ifndef BYTE_ARB_FIXED_PRIORITY_EN
    last_grant_d = grant ? sel : last_grant_q;
`endif
    case (state_q)
      ISSUE: begin
        if (grant && (CYCLES > 1)) begin
          state_d = GAP;
          gap_d   = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_q <= 4'd1) begin
          state_d = ISSUE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: begin
        state_d = ISSUE;
        gap_d   = '0;
      end
    endcase
  end

  // Control and holding registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ISSUE;
      gap_q        <= '0;
      err_orphan_q <= 1'b0;
      rd_data0_q   <= '0;
      rd_data1_q   <= '0;
`ifndef BYTE_ARB_FIXED_PRIORITY_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      err_orphan_q <= err_orphan_d;
      rd_data0_q   <= rd_data0_d;
      rd_data1_q   <= rd_data1_d;
`ifndef BYTE_ARB_FIXED_PRIORITY_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

endmodule

// File: tb/tb_byte_port_arbiter.sv
// Directed bench for byte_port_arbiter: one instance with CYCLES=1 and
// one with CYCLES=3, sharing clock, reset and requester stimulus.
module tb_byte_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rq0_rd = 1'b0, rq0_wr = 1'b0, rq1_rd = 1'b0, rq1_wr = 1'b0;
  logic [23:0] rq0_addr = '0, rq1_addr = '0;
  logic [7:0]  rq0_wr_data = '0, rq1_wr_data = '0;
  logic [7:0]  mem_rd_data = '0;
  logic        mem_rd_data_valid = 1'b0;

  logic        a_rq0_ready, a_rq1_ready, a_rq0_v, a_rq1_v, a_mem_rd, a_mem_wr, a_err;
  logic [7:0]  a_rq0_data, a_rq1_data, a_mem_wdata;
  logic [23:0] a_mem_addr;
  logic        b_rq0_ready, b_rq1_ready, b_rq0_v, b_rq1_v, b_mem_rd, b_mem_wr, b_err;
  logic [7:0]  b_rq0_data, b_rq1_data, b_mem_wdata;
  logic [23:0] b_mem_addr;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  byte_port_arbiter #(.ADDR_WIDTH(24), .CYCLES(1), .MAX_OUTSTANDING(4)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .rq0_rd(rq0_rd), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wr_data(rq0_wr_data),
    .rq0_ready(a_rq0_ready), .rq0_rd_data(a_rq0_data), .rq0_rd_data_valid(a_rq0_v),
    .rq1_rd(rq1_rd), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wr_data(rq1_wr_data),
    .rq1_ready(a_rq1_ready), .rq1_rd_data(a_rq1_data), .rq1_rd_data_valid(a_rq1_v),
    .mem_rd(a_mem_rd), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wdata),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid), .err_orphan(a_err)
  );

  byte_port_arbiter #(.ADDR_WIDTH(24), .CYCLES(3), .MAX_OUTSTANDING(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .rq0_rd(rq0_rd), .rq0_wr(rq0_wr), .rq0_addr(rq0_addr), .rq0_wr_data(rq0_wr_data),
    .rq0_ready(b_rq0_ready), .rq0_rd_data(b_rq0_data), .rq0_rd_data_valid(b_rq0_v),
    .rq1_rd(rq1_rd), .rq1_wr(rq1_wr), .rq1_addr(rq1_addr), .rq1_wr_data(rq1_wr_data),
    .rq1_ready(b_rq1_ready), .rq1_rd_data(b_rq1_data), .rq1_rd_data_valid(b_rq1_v),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wdata),
    .mem_rd_data(mem_rd_data), .mem_rd_data_valid(mem_rd_data_valid), .err_orphan(b_err)
  );

  task automatic clear_inputs();
    rq0_rd = 1'b0; rq0_wr = 1'b0; rq1_rd = 1'b0; rq1_wr = 1'b0;
    rq0_addr = '0; rq1_addr = '0; rq0_wr_data = '0; rq1_wr_data = '0;
    mem_rd_data = '0; mem_rd_data_valid = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rq0_wr = 1'b1; rq1_rd = 1'b1; mem_rd_data_valid = 1'b1; mem_rd_data = 8'hEE;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if ({a_rq0_ready, a_rq1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready got %b%b exp 00", a_rq0_ready, a_rq1_ready); end
    n_vec++; if ({a_mem_rd, a_mem_wr} !== 2'b00) begin n_err++; $display("FAIL reset_mem_cmd got %b%b exp 00", a_mem_rd, a_mem_wr); end
    n_vec++; if ({a_rq0_v, a_rq1_v, a_err} !== 3'b000) begin n_err++; $display("FAIL reset_valid_err got %b exp 000", {a_rq0_v, a_rq1_v, a_err}); end
    n_vec++; if ({a_rq0_data, a_rq1_data} !== 16'h0000) begin n_err++; $display("FAIL reset_rd_data got %h exp 0000", {a_rq0_data, a_rq1_data}); end
    do_reset();
  endtask

  task automatic test_arbitration();
    logic exp1;
    do_reset();
    rq0_wr = 1'b1; rq0_addr = 24'h000100; rq0_wr_data = 8'hA0;
    rq1_wr = 1'b1; rq1_addr = 24'h000200; rq1_wr_data = 8'hB1;
    for (int i = 0; i < 4; i++) begin
`ifdef BYTE_ARB_FIXED_PRIORITY_EN
      exp1 = 1'b0;
`else
      exp1 = (i % 2 == 1);
`endif
      #2;
      n_vec++; if ({a_rq0_ready, a_rq1_ready} !== {~exp1, exp1}) begin n_err++; $display("FAIL arb_grant[%0d] got %b%b exp %b%b", i, a_rq0_ready, a_rq1_ready, ~exp1, exp1); end
      n_vec++; if ({a_mem_wr, a_mem_rd} !== 2'b10) begin n_err++; $display("FAIL arb_mem_wr[%0d] got wr=%b rd=%b exp wr=1 rd=0", i, a_mem_wr, a_mem_rd); end
      n_vec++; if ({a_mem_addr, a_mem_wdata} !== (exp1 ? {24'h000200, 8'hB1} : {24'h000100, 8'hA0})) begin n_err++; $display("FAIL arb_mem_addr_data[%0d] got %h/%h", i, a_mem_addr, a_mem_wdata); end
      @(negedge clk);
    end
    rq0_wr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_vec++; if ({a_rq0_ready, a_rq1_ready} !== 2'b01) begin n_err++; $display("FAIL arb_single[%0d] got %b%b exp 01", i, a_rq0_ready, a_rq1_ready); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_gap();
    logic        exp_rd;
    logic [23:0] exp_addr;
    do_reset();
    rq0_rd = 1'b1;
    for (int c = 0; c < 4; c++) begin
      rq0_addr = (c == 0) ? 24'h000010 : 24'h000011;
      exp_rd   = (c == 0) || (c == 3);
      exp_addr = exp_rd ? rq0_addr : 24'h000000;
      #2;
      n_vec++; if ({b_mem_rd, b_rq0_ready, b_rq1_ready} !== {exp_rd, exp_rd, 1'b0}) begin n_err++; $display("FAIL gap_cmd[%0d] got rd=%b rdy=%b%b exp rd=%b", c, b_mem_rd, b_rq0_ready, b_rq1_ready, exp_rd); end
      n_vec++; if (b_mem_addr !== exp_addr) begin n_err++; $display("FAIL gap_addr[%0d] got %h exp %h", c, b_mem_addr, exp_addr); end
      @(negedge clk);
    end
    rq0_rd = 1'b0;
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'hA5;
    #2;
    n_vec++; if ({b_rq0_v, b_rq1_v, b_rq0_data} !== {2'b10, 8'hA5}) begin n_err++; $display("FAIL gap_ret0 got v=%b%b d=%h exp v=10 d=a5", b_rq0_v, b_rq1_v, b_rq0_data); end
    @(negedge clk);
    mem_rd_data = 8'h5A;
    #2;
    n_vec++; if ({b_rq0_v, b_rq1_v, b_rq0_data} !== {2'b10, 8'h5A}) begin n_err++; $display("FAIL gap_ret1 got v=%b%b d=%h exp v=10 d=5a", b_rq0_v, b_rq1_v, b_rq0_data); end
    @(negedge clk);
    mem_rd_data_valid = 1'b0; mem_rd_data = 8'hC3;
    #2;
    n_vec++; if ({b_rq0_v, b_rq0_data, b_err} !== {1'b0, 8'h5A, 1'b0}) begin n_err++; $display("FAIL gap_hold got v=%b d=%h err=%b exp v=0 d=5a err=0", b_rq0_v, b_rq0_data, b_err); end
    clear_inputs();
  endtask

  task automatic test_interleave();
    do_reset();
    rq0_rd = 1'b1; rq0_addr = 24'h000020; rq1_rd = 1'b1; rq1_addr = 24'h000030;
    #2;
    n_vec++; if ({a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr} !== {3'b101, 24'h000020}) begin n_err++; $display("FAIL il_issue0 got rdy=%b%b rd=%b a=%h", a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr); end
    @(negedge clk);
    rq0_addr = 24'h000021;
    #2;
    n_vec++; if ({a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr} !== {3'b011, 24'h000030}) begin n_err++; $display("FAIL il_issue1 got rdy=%b%b rd=%b a=%h", a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr); end
    @(negedge clk);
    rq1_rd = 1'b0;
    #2;
    n_vec++; if ({a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr} !== {3'b101, 24'h000021}) begin n_err++; $display("FAIL il_issue2 got rdy=%b%b rd=%b a=%h", a_rq0_ready, a_rq1_ready, a_mem_rd, a_mem_addr); end
    @(negedge clk);
    rq0_rd = 1'b0;
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'h01;
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v, a_rq0_data} !== {2'b10, 8'h01}) begin n_err++; $display("FAIL il_ret0 got v=%b%b d=%h exp v=10 d=01", a_rq0_v, a_rq1_v, a_rq0_data); end
    @(negedge clk);
    mem_rd_data = 8'h02;
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v, a_rq1_data, a_rq0_data} !== {2'b01, 8'h02, 8'h01}) begin n_err++; $display("FAIL il_ret1 got v=%b%b d1=%h d0=%h exp v=01 d1=02 d0=01", a_rq0_v, a_rq1_v, a_rq1_data, a_rq0_data); end
    @(negedge clk);
    mem_rd_data = 8'h03;
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v, a_rq0_data, a_rq1_data} !== {2'b10, 8'h03, 8'h02}) begin n_err++; $display("FAIL il_ret2 got v=%b%b d0=%h d1=%h exp v=10 d0=03 d1=02", a_rq0_v, a_rq1_v, a_rq0_data, a_rq1_data); end
    @(negedge clk);
    clear_inputs();
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v, a_err} !== 3'b000) begin n_err++; $display("FAIL il_idle got %b exp 000", {a_rq0_v, a_rq1_v, a_err}); end
  endtask

  task automatic test_fifo_full();
    do_reset();
    rq0_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rq0_addr = 24'h000040 + 24'(i);
      #2;
      n_vec++; if ({a_rq0_ready, a_mem_rd} !== 2'b11) begin n_err++; $display("FAIL full_fill[%0d] got rdy=%b rd=%b exp 11", i, a_rq0_ready, a_mem_rd); end
      @(negedge clk);
    end
    rq0_addr = 24'h000044;
    rq1_wr = 1'b1; rq1_addr = 24'h000300; rq1_wr_data = 8'h3C;
    #2;
    n_vec++; if ({a_rq0_ready, a_rq1_ready, a_mem_wr, a_mem_rd, a_mem_addr} !== {4'b0110, 24'h000300}) begin n_err++; $display("FAIL full_write_passes got rdy=%b%b wr=%b rd=%b a=%h", a_rq0_ready, a_rq1_ready, a_mem_wr, a_mem_rd, a_mem_addr); end
    @(negedge clk);
    rq1_wr = 1'b0;
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'h11;
    #2;
    n_vec++; if ({a_rq0_ready, a_mem_rd, a_rq0_v} !== 3'b001) begin n_err++; $display("FAIL full_stall_on_return got rdy=%b rd=%b v=%b exp 001", a_rq0_ready, a_mem_rd, a_rq0_v); end
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    #2;
    n_vec++; if ({a_rq0_ready, a_mem_rd, a_mem_addr} !== {2'b11, 24'h000044}) begin n_err++; $display("FAIL full_fifth_granted got rdy=%b rd=%b a=%h", a_rq0_ready, a_mem_rd, a_mem_addr); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_orphan();
    do_reset();
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'h77;
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v, a_err} !== 3'b000) begin n_err++; $display("FAIL orphan_drop got %b exp 000", {a_rq0_v, a_rq1_v, a_err}); end
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    #2;
    n_vec++; if (a_err !== 1'b1) begin n_err++; $display("FAIL orphan_set got %b exp 1", a_err); end
    @(negedge clk);
    #2;
    n_vec++; if ({a_err, a_rq0_data, a_rq1_data} !== {1'b1, 16'h0000}) begin n_err++; $display("FAIL orphan_sticky got err=%b d=%h%h exp 1/0000", a_err, a_rq0_data, a_rq1_data); end
    reset_n = 1'b0;
    #1;
    n_vec++; if (a_err !== 1'b0) begin n_err++; $display("FAIL orphan_reset_clear got %b exp 0", a_err); end
    @(negedge clk);
    reset_n = 1'b1;
    rq0_rd = 1'b1; rq0_addr = 24'h000005;
    #2;
    n_vec++; if ({a_rq0_ready, a_mem_rd} !== 2'b11) begin n_err++; $display("FAIL orphan_pre_read got %b%b exp 11", a_rq0_ready, a_mem_rd); end
    @(negedge clk);
    rq0_rd = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    mem_rd_data_valid = 1'b1; mem_rd_data = 8'h99;
    #2;
    n_vec++; if ({a_rq0_v, a_rq1_v} !== 2'b00) begin n_err++; $display("FAIL orphan_forgotten_valid got %b%b exp 00", a_rq0_v, a_rq1_v); end
    @(negedge clk);
    mem_rd_data_valid = 1'b0;
    #2;
    n_vec++; if (a_err !== 1'b1) begin n_err++; $display("FAIL orphan_forgotten_err got %b exp 1", a_err); end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arbitration();
    test_gap();
    test_interleave();
    test_fifo_full();
    test_orphan();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/byte_port_arbiter.md
BYTE_PORT_ARBITER -- requirements
Module: byte_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 24, SHALL set the byte address width of both requester ports and the memory port.
REQ-002 Parameter CYCLES, default 1, range 1..15, SHALL set the minimum number of clocks between consecutive memory commands.
REQ-003 Parameter MAX_OUTSTANDING, default 4, power of two from 2 to 16, SHALL set the depth of the read-owner FIFO.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all logic is on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-006 Ports rq0_rd and rq1_rd, inputs, 1 bit each, SHALL be per-requester read commands, held until accepted.
REQ-007 Ports rq0_wr and rq1_wr, inputs, 1 bit each, SHALL be per-requester write commands; rd and wr are never both high on one requester.
REQ-008 Ports rq0_addr and rq1_addr, inputs, ADDR_WIDTH bits, SHALL be the byte addresses.
REQ-009 Ports rq0_wr_data and rq1_wr_data, inputs, 8 bits, SHALL be the write bytes.
REQ-010 Ports rq0_ready and rq1_ready, outputs, 1 bit each, SHALL indicate command accepted this cycle, Moore-free combinational grant.
REQ-011 Ports rq0_rd_data and rq1_rd_data, outputs, 8 bits, and rq0_rd_data_valid and rq1_rd_data_valid, outputs, 1 bit each, SHALL return read bytes.
REQ-012 Ports mem_rd and mem_wr, outputs, 1 bit each, mem_addr, output, ADDR_WIDTH bits, and mem_wr_data, output, 8 bits, SHALL be single-cycle memory commands.
REQ-013 Ports mem_rd_data, input, 8 bits, and mem_rd_data_valid, input, 1 bit, SHALL return read data in issue order.
REQ-014 Port err_orphan, output, 1 bit, SHALL be a sticky flag for read data arriving with no outstanding read.

Function
REQ-015 The state machine SHALL have state ISSUE (command may issue) and state GAP (spacing countdown).
REQ-016 In ISSUE, a pending eligible request SHALL be granted: rqN_ready=1, with mem_rd/mem_wr, mem_addr and mem_wr_data driven combinationally from requester N in the same cycle.
REQ-017 A read SHALL be eligible only when the owner FIFO is not full at the start of the cycle; a write is always eligible.
REQ-018 When both requesters are eligible, round-robin SHALL apply: the requester not granted last wins.
REQ-019 A single eligible requester SHALL win regardless of history.
REQ-020 On a grant with CYCLES>1, the block SHALL enter GAP for CYCLES-1 clocks, then return to ISSUE; with CYCLES=1 it SHALL stay in ISSUE, giving one grant per clock.
REQ-021 In GAP, all ready and mem command outputs SHALL be 0.
REQ-022 Each granted read SHALL push the owner ID onto the FIFO.
REQ-023 Each mem_rd_data_valid with a non-empty FIFO SHALL pop the head and pulse rqH_rd_data_valid for one clock, with rqH_rd_data = mem_rd_data, zero added latency, where H is the head owner.
REQ-024 A simultaneous push and pop SHALL both take effect, and the count SHALL be unchanged.
REQ-025 mem_rd_data_valid with an empty FIFO SHALL be dropped, with no requester valid, and SHALL set err_orphan.
REQ-026 Non-owner rd_data outputs SHALL hold their last value.

Reset
REQ-027 Assertion of reset_n=0 SHALL clear, asynchronously: state to ISSUE, gap counter, FIFO pointers and count, err_orphan, and both rd_data_valid and rd_data (to 0); the last-grant register is set to 1, so requester 0 wins first.
REQ-028 Reads outstanding at reset SHALL be forgotten; their later data returns SHALL count as orphans.
REQ-029 Combinational outputs SHALL be 0 while reset_n=0.

Configuration
REQ-030 With BYTE_ARB_FIXED_PRIORITY_EN defined, requester 0 SHALL always win contention and the last-grant register is absent.
REQ-031 Without BYTE_ARB_FIXED_PRIORITY_EN, round-robin per REQ-018 SHALL apply.

Structure
REQ-032 Package byte_arb_pkg SHALL hold typedef owner_t (1 bit), the state enum (ISSUE, GAP), and constant NUM_REQ=2.
REQ-033 The owner FIFO SHALL be sub-module owner_fifo, with push, pop, din, dout, full, empty and MAX_OUTSTANDING depth.

Verification
REQ-034 Both requesters write every cycle, CYCLES=1: grants SHALL alternate 0,1,0,1, with mem_wr high every clock.
REQ-035 CYCLES=3, rq0 reads 0x10, 0x11: mem_rd SHALL be high on cycles 0 and 3 only; the data returns 0xA5 and 0x5A SHALL reach rq0 in order.
REQ-036 Interleaved reads rq0@0x20, rq1@0x30, rq0@0x21 with returns 0x01, 0x02, 0x03: rq0 SHALL get 0x01 then 0x03, and rq1 SHALL get 0x02.
REQ-037 MAX_OUTSTANDING=4, five reads with no returns: the fifth read SHALL stall, while a concurrent write from rq1 is still granted; the fifth read SHALL be granted in the cycle after the first return.
REQ-038 mem_rd_data_valid with no read outstanding: err_orphan SHALL set and stay set, with no requester valid; reset_n low SHALL clear it.
REQ-039 With BYTE_ARB_FIXED_PRIORITY_EN and continuous contention, rq0 SHALL win every cycle.
